// File: rtl/daq_cmd_pkg.sv
// Shared command codes, pending-bit layout and FSM encoding for the DAQ command sequencer.
package daq_cmd_pkg;

  localparam logic [3:0] CMD_RESET_DIF   = 4'h0;
  localparam logic [3:0] CMD_RESET_BCID  = 4'h1;
  localparam logic [3:0] CMD_START_ACQ   = 4'h2;
  localparam logic [3:0] CMD_RAMFULL_EXT = 4'h3;
  localparam logic [3:0] CMD_STOP_ACQ    = 4'h5;
  localparam logic [3:0] CMD_IDLE        = 4'hE;

  // Lower index means higher dispatch priority.
  localparam int NUM_CMDS    = 5;
  localparam int PB_RST_DIF  = 0;
  localparam int PB_RST_BCID = 1;
  localparam int PB_RAMFULL  = 2;
  localparam int PB_STOP     = 3;
  localparam int PB_START    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [NUM_CMDS-1:0] code_to_mask(input logic [3:0] code);
    logic [NUM_CMDS-1:0] m;
    m = '0;
    case (code)
      CMD_RESET_DIF:   m[PB_RST_DIF]  = 1'b1;
      CMD_RESET_BCID:  m[PB_RST_BCID] = 1'b1;
      CMD_START_ACQ:   m[PB_START]    = 1'b1;
      CMD_RAMFULL_EXT: m[PB_RAMFULL]  = 1'b1;
      CMD_STOP_ACQ:    m[PB_STOP]     = 1'b1;
      default:         m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] idx_to_code(input int idx);
    logic [3:0] c;
    case (idx)
      PB_RST_DIF:  c = CMD_RESET_DIF;
      PB_RST_BCID: c = CMD_RESET_BCID;
      PB_RAMFULL:  c = CMD_RAMFULL_EXT;
      PB_STOP:     c = CMD_STOP_ACQ;
      PB_START:    c = CMD_START_ACQ;
      default:     c = CMD_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/daq_cmd_sequencer_if.sv
// HPS request strobe plus command-bus and status signals of the DAQ command sequencer.
interface daq_cmd_sequencer_if;
  import daq_cmd_pkg::*;

  logic                h2f_cmd_req;
  logic [3:0]          h2f_cmd_code;
  logic [3:0]          cmd_code;
  logic                cmd_busy;
  logic [NUM_CMDS-1:0] pending;
  logic                acq_running;
  logic                err_illegal;
  logic [7:0]          drop_cnt;
  logic                restart_pending;

  modport master (
    output h2f_cmd_req, h2f_cmd_code,
    input  cmd_code, cmd_busy, pending, acq_running, err_illegal, drop_cnt, restart_pending
  );

  modport slave (
    input  h2f_cmd_req, h2f_cmd_code,
    output cmd_code, cmd_busy, pending, acq_running, err_illegal, drop_cnt, restart_pending
  );

endinterface

// File: rtl/daq_cmd_prio_arb.sv
// Fixed-priority pick over the pending mask: one-hot grant and its command code.
// Purely combinational; no handshake, an empty mask yields grant=0 and the idle code.
module daq_cmd_prio_arb
  import daq_cmd_pkg::*;
(
  input  logic [NUM_CMDS-1:0] req,
  output logic [NUM_CMDS-1:0] grant,
  output logic [3:0]          code
);

  // Scan from lowest priority upward so the highest-priority request lands last.
  always_comb begin
    grant = '0;
    code  = CMD_IDLE;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        code     = idx_to_code(i);
      end
    end
  end

endmodule

// File: rtl/daq_cmd_sequencer.sv
// Queues HPS commands (one per kind), dispatches by priority onto cmd_code with hold/gap framing.
// Latency: request at edge k drives cmd_code from edge k+1 when idle; optional DAQ_AUTO_RESTART_EN.
// No backpressure: duplicate, illegal or redundant-start requests are dropped and counted.
module daq_cmd_sequencer
  import daq_cmd_pkg::*;
#(
  parameter int CMD_HOLD      = 2,
  parameter int GAP_CYCLES    = 4,
  parameter int RESTART_DELAY = 1000
) (
  input  logic                clk_50,
  input  logic                rst,
  daq_cmd_sequencer_if.slave  bus
);

  localparam int HCNT_W = (CMD_HOLD > 1) ? $clog2(CMD_HOLD) : 1;
  localparam int GCNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t              state_q, state_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
  logic [3:0]          cmd_code_q, cmd_code_d;
  logic [NUM_CMDS-1:0] pending_q, pending_d;
  logic                acq_running_q, acq_running_d;
  logic                err_illegal_q, err_illegal_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;

  logic [NUM_CMDS-1:0] grant;
  logic [3:0]          grant_code;
  logic [NUM_CMDS-1:0] req_mask;
  logic [NUM_CMDS-1:0] clr_mask;
  logic [NUM_CMDS-1:0] set_mask;
  logic [NUM_CMDS-1:0] auto_set;
  logic                req_legal;
  logic                req_illegal;
  logic                dispatch;
  logic                merge;
  logic                start_block;
  logic                drop;

  daq_cmd_prio_arb u_arb (
    .req   (pending_q),
    .grant (grant),
    .code  (grant_code)
  );

  always_comb begin
    req_mask    = code_to_mask(bus.h2f_cmd_code);
    req_legal   = bus.h2f_cmd_req & (|req_mask);
    req_illegal = bus.h2f_cmd_req & ~(|req_mask);
    dispatch    = (state_q == ST_IDLE) & (|pending_q);
    clr_mask    = dispatch ? grant : '0;
    // A bit being dispatched on this edge is not a merge: the new request re-arms it.
    merge       = req_legal & (|(req_mask & pending_q & ~clr_mask));
    start_block = req_legal & req_mask[PB_START] & acq_running_q
                  & ~(|pending_q[PB_STOP:PB_RST_DIF]);
    drop        = req_illegal | merge | start_block;
    set_mask    = (req_legal & ~start_block) ? req_mask : '0;

    pending_d = pending_q & ~clr_mask;
    if (req_legal & req_mask[PB_RST_DIF]) begin
      pending_d[PB_START]   = 1'b0;
      pending_d[PB_STOP]    = 1'b0;
      pending_d[PB_RAMFULL] = 1'b0;
    end
    pending_d = pending_d | set_mask | auto_set;

    err_illegal_d = err_illegal_q | req_illegal;
    drop_cnt_d    = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_comb begin
    state_d       = state_q;
    hcnt_d        = hcnt_q;
    gcnt_d        = gcnt_q;
    cmd_code_d    = cmd_code_q;
    acq_running_d = acq_running_q;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          cmd_code_d    = grant_code;
          hcnt_d        = HCNT_W'(CMD_HOLD - 1);
          acq_running_d = grant[PB_START];
          state_d       = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hcnt_q == '0) begin
          cmd_code_d = CMD_IDLE;
          gcnt_d     = GCNT_W'(GAP_CYCLES - 1);
          state_d    = ST_GAP;
        end else begin
          hcnt_d = hcnt_q - HCNT_W'(1);
        end
      end
      ST_GAP: begin
        if (gcnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q - GCNT_W'(1);
        end
      end
      default: begin
        cmd_code_d = CMD_IDLE;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hcnt_q        <= '0;
      gcnt_q        <= '0;
      cmd_code_q    <= CMD_IDLE;
      pending_q     <= '0;
      acq_running_q <= 1'b0;
      err_illegal_q <= 1'b0;
      drop_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      gcnt_q        <= gcnt_d;
      cmd_code_q    <= cmd_code_d;
      pending_q     <= pending_d;
      acq_running_q <= acq_running_d;
      err_illegal_q <= err_illegal_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

`ifdef DAQ_AUTO_RESTART_EN
  localparam int RCNT_W = $clog2(RESTART_DELAY + 1);
  localparam logic [NUM_CMDS-1:0] CANCEL_MASK =
    NUM_CMDS'((1 << PB_STOP) | (1 << PB_RST_BCID) | (1 << PB_RST_DIF));

  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              restart_q, restart_d;
  logic              cancel;

  always_comb begin
    rcnt_d    = rcnt_q;
    restart_d = restart_q;
    auto_set  = '0;
    cancel    = (req_legal & (|(req_mask & CANCEL_MASK)))
              | (dispatch & (|(grant & CANCEL_MASK)));
    if (cancel) begin
      restart_d = 1'b0;
    end else if (dispatch & grant[PB_RAMFULL] & acq_running_q) begin
      rcnt_d    = RCNT_W'(RESTART_DELAY);
      restart_d = 1'b1;
    end else if (restart_q) begin
      if (rcnt_q == '0) begin
        auto_set[PB_START] = 1'b1;
        restart_d          = 1'b0;
      end else begin
        rcnt_d = rcnt_q - RCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      rcnt_q    <= '0;
      restart_q <= 1'b0;
    end else begin
      rcnt_q    <= rcnt_d;
      restart_q <= restart_d;
    end
  end

  assign bus.restart_pending = restart_q;
`else
  logic unused_cfg;
  assign unused_cfg          = (RESTART_DELAY != 0);
  assign auto_set            = '0;
  assign bus.restart_pending = 1'b0;
`endif

  assign bus.cmd_code    = cmd_code_q;
  assign bus.pending     = pending_q;
  assign bus.acq_running = acq_running_q;
  assign bus.err_illegal = err_illegal_q;
  assign bus.drop_cnt    = drop_cnt_q;
  assign bus.cmd_busy    = (state_q != ST_IDLE) | (|pending_q);

endmodule

// File: tb/tb_daq_cmd_sequencer.sv
// Directed bench for daq_cmd_sequencer: bus ordering, framing, drops, reset and auto-restart.
module tb_daq_cmd_sequencer;
  import daq_cmd_pkg::*;

  localparam int HOLD  = 2;
  localparam int GAP   = 4;
  localparam int DELAY = 10;

  logic clk_50;
  logic rst;
  int   n_checks;
  int   n_fail;

  daq_cmd_sequencer_if bus ();

  daq_cmd_sequencer #(
    .CMD_HOLD      (HOLD),
    .GAP_CYCLES    (GAP),
    .RESTART_DELAY (DELAY)
  ) dut (
    .clk_50 (clk_50),
    .rst    (rst),
    .bus    (bus.slave)
  );

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  logic [3:0] trace[$];
  bit         log_en;
  int         run_code[8];
  int         run_len[8];
  int         run_start[8];
  int         n_runs;

  always @(negedge clk_50) if (log_en) trace.push_back(bus.cmd_code);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic send_req(input logic [3:0] code);
    bus.h2f_cmd_req  = 1'b1;
    bus.h2f_cmd_code = code;
    tick();
    bus.h2f_cmd_req  = 1'b0;
    bus.h2f_cmd_code = 4'h0;
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_cmd"},     bus.cmd_code, CMD_IDLE);
    check_val({tag, "_pend"},    bus.pending, 0);
    check_val({tag, "_acq"},     bus.acq_running, 0);
    check_val({tag, "_err"},     bus.err_illegal, 0);
    check_val({tag, "_drop"},    bus.drop_cnt, 0);
    check_val({tag, "_restart"}, bus.restart_pending, 0);
    check_val({tag, "_busy"},    bus.cmd_busy, 0);
  endtask

  task automatic start_log();
    trace.delete();
    log_en = 1'b1;
  endtask

  task automatic get_runs();
    n_runs = 0;
    for (int i = 0; i < trace.size(); i++) begin
      if (trace[i] != CMD_IDLE) begin
        if (i == 0 || trace[i-1] != trace[i]) begin
          if (n_runs < 8) begin
            run_code[n_runs]  = int'(trace[i]);
            run_start[n_runs] = i;
            run_len[n_runs]   = 1;
          end
          n_runs++;
        end else if (n_runs <= 8) begin
          run_len[n_runs-1]++;
        end
      end
    end
  endtask

  // exp_codes holds the expected bus order, first code in the low nibble.
  task automatic check_seq(input string tag, input logic [15:0] exp_codes, input int n_exp);
    int gap;
    log_en = 1'b0;
    get_runs();
    check_val({tag, "_nruns"}, n_runs, n_exp);
    for (int i = 0; i < n_exp && i < n_runs && i < 8; i++) begin
      check_val($sformatf("%s_code%0d", tag, i), run_code[i], exp_codes[4*i +: 4]);
      check_val($sformatf("%s_hold%0d", tag, i), run_len[i], HOLD);
      if (i > 0) begin
        gap = run_start[i] - (run_start[i-1] + run_len[i-1]);
        check_val($sformatf("%s_gap%0d", tag, i), (gap >= GAP) ? 1 : 0, 1);
      end
    end
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    log_en           = 1'b0;
    rst              = 1'b1;
    bus.h2f_cmd_req  = 1'b0;
    bus.h2f_cmd_code = 4'h0;
    repeat (3) tick();
    check_reset("rst0");
    rst = 1'b0;
    tick();

    // 1: single start, exact latency and gap timing of cmd_busy
    start_log();
    send_req(CMD_START_ACQ);
    repeat (6) tick();
    check_val("t1_busy_in_gap", bus.cmd_busy, 1);
    tick();
    check_val("t1_busy_done", bus.cmd_busy, 0);
    check_val("t1_acq", bus.acq_running, 1);
    repeat (3) tick();
    get_runs();
    check_val("t1_first_idx", (n_runs > 0) ? run_start[0] : -1, 2);
    check_seq("t1", 16'h0002, 1);

    rst = 1'b1;
    tick();
    check_reset("rst1");
    rst = 1'b0;

    // 2: start, stop, bcid back to back; bcid outranks the stop
    start_log();
    send_req(CMD_START_ACQ);
    send_req(CMD_STOP_ACQ);
    send_req(CMD_RESET_BCID);
    repeat (30) tick();
    check_seq("t2", 16'h0512, 3);
    check_val("t2_acq", bus.acq_running, 0);
    check_val("t2_drop", bus.drop_cnt, 0);

    // 3: illegal code, then a merged start behind a stop
    send_req(4'h7);
    repeat (3) tick();
    check_val("t3_err", bus.err_illegal, 1);
    check_val("t3_drop_illegal", bus.drop_cnt, 1);
    check_val("t3_cmd_idle", bus.cmd_code, CMD_IDLE);
    check_val("t3_pend_empty", bus.pending, 0);
    start_log();
    send_req(CMD_STOP_ACQ);
    send_req(CMD_START_ACQ);
    send_req(CMD_START_ACQ);
    check_val("t3_drop_merge", bus.drop_cnt, 2);
    repeat (25) tick();
    check_seq("t3", 16'h0025, 2);
    check_val("t3_acq", bus.acq_running, 1);
    send_req(CMD_START_ACQ);
    check_val("t3_start_block_drop", bus.drop_cnt, 3);
    check_val("t3_start_block_pend", bus.pending, 0);
    repeat (3) tick();
    check_val("t3_start_block_cmd", bus.cmd_code, CMD_IDLE);

    // 4: reset_dif flushes pending start/stop
    start_log();
    send_req(CMD_RESET_BCID);
    send_req(CMD_STOP_ACQ);
    send_req(CMD_START_ACQ);
    check_val("t4_pend_ss", bus.pending, 5'b11000);
    send_req(CMD_RESET_DIF);
    check_val("t4_pend_dif", bus.pending, 5'b00001);
    repeat (20) tick();
    check_seq("t4", 16'h0001, 2);
    check_val("t4_acq", bus.acq_running, 0);
    check_val("t4_drop", bus.drop_cnt, 3);

    // drop counter saturation, idle code counts as illegal
    for (int i = 0; i < 260; i++) send_req(CMD_IDLE);
    check_val("sat_drop", bus.drop_cnt, 8'hFF);
    check_val("sat_err", bus.err_illegal, 1);
    check_val("sat_pend", bus.pending, 0);

    // 5: reset in the middle of a command; it is not resent
    send_req(CMD_RESET_BCID);
    tick();
    check_val("t5_sending", bus.cmd_code, CMD_RESET_BCID);
    rst = 1'b1;
    tick();
    check_reset("t5_rst");
    rst = 1'b0;
    repeat (10) tick();
    check_val("t5_no_resend", bus.cmd_code, CMD_IDLE);
    check_val("t5_busy", bus.cmd_busy, 0);

    // 6: ramfull while running, then ramfull cancelled by stop
    send_req(CMD_START_ACQ);
    repeat (10) tick();
    check_val("t6_running", bus.acq_running, 1);
    start_log();
    send_req(CMD_RAMFULL_EXT);
    tick();
`ifdef DAQ_AUTO_RESTART_EN
    check_val("t6_restart_on", bus.restart_pending, 1);
    repeat (30) tick();
    check_seq("t6a", 16'h0023, 2);
    check_val("t6a_spacing", (n_runs >= 2) ? run_start[1] - run_start[0] : -1, DELAY + 2);
    check_val("t6a_restart_off", bus.restart_pending, 0);
    check_val("t6a_acq", bus.acq_running, 1);
`else
    check_val("t6_restart_tied", bus.restart_pending, 0);
    repeat (30) tick();
    check_seq("t6a", 16'h0003, 1);
    check_val("t6a_acq", bus.acq_running, 0);
`endif
    start_log();
    send_req(CMD_RAMFULL_EXT);
    tick();
    tick();
`ifdef DAQ_AUTO_RESTART_EN
    check_val("t6b_restart_on", bus.restart_pending, 1);
`else
    check_val("t6b_restart_tied", bus.restart_pending, 0);
`endif
    send_req(CMD_STOP_ACQ);
    check_val("t6b_cancel", bus.restart_pending, 0);
    repeat (30) tick();
    check_seq("t6b", 16'h0053, 2);
    check_val("t6b_acq", bus.acq_running, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
